operand_b_stage: RTL

OPERAND_B_STAGE -- requirements
Module: operand_b_stage

---
 rtl/riscv_defs.sv | 14 +
 rtl/operand_b_fwd_sel.sv | 69 ++++++
 rtl/operand_b_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/riscv_defs.sv
// Shared RISC-V pipeline definitions: default widths and forwarding source codes.
// Used by the operand B stage and by the hazard unit.
package riscv_defs;

  localparam int XLEN_DEF = 64;
  localparam int RA_W_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_src_e;

endpackage

// File: rtl/operand_b_fwd_sel.sv
// Operand B forwarding mux and immediate select, purely combinational.
// Ports: rf/imm/rs2 + EX and MEM writeback candidates in; op_b/st_data/fwd_src next out.
// Forwarding is compiled in only when OPB_STAGE_FWD_EN is defined.
module operand_b_fwd_sel
  import riscv_defs::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int IMM_W = 32,
  parameter int RA_W  = RA_W_DEF
) (
  input  logic [XLEN-1:0]  rf_data,
  input  logic [IMM_W-1:0] imm,
  input  logic             sel_imm,
  input  logic [RA_W-1:0]  rs2,
  input  logic             ex_wr_en,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_wr_en,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  output logic [XLEN-1:0]  op_b_next,
  output logic [XLEN-1:0]  st_data_next,
  output fwd_src_e         fwd_src_next
);

  logic [XLEN-1:0] imm_sx;
  logic [XLEN-1:0] reg_val;

  generate
    if (IMM_W < XLEN) begin : g_sext
      assign imm_sx = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    end else begin : g_pass
      assign imm_sx = imm;
    end
  endgenerate

`ifdef OPB_STAGE_FWD_EN
  logic ex_hit;
  logic mem_hit;

  // x0 never forwards: writes to it are discarded architecturally.
  assign ex_hit  = ex_wr_en && (ex_rd != '0) && (ex_rd == rs2);
  assign mem_hit = mem_wr_en && (mem_rd != '0) && (mem_rd == rs2);

  // EX holds the younger result, so it wins over MEM.
  always_comb begin
    reg_val      = rf_data;
    fwd_src_next = FWD_RF;
    if (ex_hit) begin
      reg_val      = ex_result;
      fwd_src_next = FWD_EX;
    end else if (mem_hit) begin
      reg_val      = mem_result;
      fwd_src_next = FWD_MEM;
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd   = ^{rs2, ex_wr_en, ex_rd, ex_result,
                          mem_wr_en, mem_rd, mem_result};
  assign reg_val      = rf_data;
  assign fwd_src_next = FWD_RF;
`endif

  assign op_b_next    = sel_imm ? imm_sx : reg_val;
  assign st_data_next = reg_val;

endmodule

// File: rtl/operand_b_stage.sv
// Operand B pipeline stage: forwarded/immediate operand B and store data,
// held in a valid/ready register slice (in_valid/in_ready -> out_valid/out_ready).
// Ports: clk, rst (async high), ID bundle in, EX/MEM candidates, flush, EX bundle out.
// Macro OPB_STAGE_FWD_EN enables EX/MEM forwarding in operand_b_fwd_sel.
module operand_b_stage
  import riscv_defs::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int IMM_W = 32,
  parameter int RA_W  = RA_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rf_data,
  input  logic [IMM_W-1:0] imm,
  input  logic             sel_imm,
  input  logic [RA_W-1:0]  rs2,
  input  logic             ex_wr_en,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             mem_wr_en,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic [XLEN-1:0]  mem_result,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  op_b,
  output logic [XLEN-1:0]  st_data,
  output logic [1:0]       fwd_src
);

  logic [XLEN-1:0] op_b_d;
  logic [XLEN-1:0] op_b_q;
  logic [XLEN-1:0] st_data_d;
  logic [XLEN-1:0] st_data_q;
  fwd_src_e        fwd_d;
  fwd_src_e        fwd_q;
  logic            valid_d;
  logic            valid_q;
  logic            load;

  operand_b_fwd_sel #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W),
    .RA_W  (RA_W)
  ) u_fwd_sel (
    .rf_data      (rf_data),
    .imm          (imm),
    .sel_imm      (sel_imm),
    .rs2          (rs2),
    .ex_wr_en     (ex_wr_en),
    .ex_rd        (ex_rd),
    .ex_result    (ex_result),
    .mem_wr_en    (mem_wr_en),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .op_b_next    (op_b_d),
    .st_data_next (st_data_d),
    .fwd_src_next (fwd_d)
  );

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Flush beats load, load beats drain; otherwise hold.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      op_b_q    <= '0;
      st_data_q <= '0;
      fwd_q     <= FWD_RF;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        op_b_q    <= op_b_d;
        st_data_q <= st_data_d;
        fwd_q     <= fwd_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign op_b      = op_b_q;
  assign st_data   = st_data_q;
  assign fwd_src   = fwd_q;

endmodule
